spi_txn_arbiter: RTL

- Shares one SPI master (8-bit, start/busy/new_data handshake) between NREQ requesters.
- Round-robin arbitration, a per-slave active-low select, and a full-duplex byte exchange per grant.
- Enforces select setup/hold timing around each byte.
- Sits between the peripheral controllers and the single SPI master instance.
- Replaces the testbench-style OR-of-selects start generation and the MISO select mux control.

---
 rtl/spi_txn_arbiter_pkg.sv | 28 ++
 rtl/spi_txn_arbiter_rr.sv | 31 +++
 rtl/spi_txn_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_arb_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    HOLD,
    DONE
  } state_t;

  // True in every state where the granted slave must be selected.
  function automatic logic state_selects(input state_t s);
    return (s == SETUP) || (s == START) || (s == WAIT) || (s == HOLD);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_arbiter #(
  parameter int  N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Walk the requests starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        idx_o      = pos;
        gnt_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one 8-bit SPI master between NREQ requesters: round-robin grant,
// per-slave select with setup/hold framing, and one byte exchange per grant.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int  NREQ        = 4,
  parameter int  DATA_W      = DATA_W_DEF,
  parameter int  SETUP_CYC   = 2,
  parameter int  HOLD_CYC    = 2,
  parameter int  TIMEOUT_CYC = 1024,
  localparam int SEL_W       = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [NREQ-1:0]          ss_n,
  output logic [SEL_W-1:0]         sel_id,
  output logic                     m_start,
  output logic [DATA_W-1:0]        m_data_in,
  input  logic                     m_busy,
  input  logic                     m_new_data,
  input  logic [DATA_W-1:0]        m_data_out
);

  // One counter serves setup, wait-timeout and hold since they never overlap.
  localparam int CNT_MAX = max3(SETUP_CYC, HOLD_CYC, TIMEOUT_CYC);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rsp_q, rsp_d;
  logic               err_flag_q, err_flag_d;
  logic [NREQ-1:0]    ss_n_q, ss_n_d;
  logic               m_start_q, m_start_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               err_q, err_d;
  logic [NREQ-1:0]    sel_onehot_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [SEL_W-1:0]   arb_idx;
  logic [DATA_W-1:0]  req_bytes [NREQ];

  // Unpack the flat request data bus into per-requester bytes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Next-state and datapath updates for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    tx_d       = tx_q;
    rsp_d      = rsp_q;
    err_flag_d = err_flag_q;
    m_start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d      = arb_idx;
          err_flag_d = 1'b0;
          cnt_d      = '0;
          for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) tx_d = req_bytes[i];
          end
          if (SETUP_CYC == 0) begin
            state_d   = START;
            m_start_d = !m_busy;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d     = '0;
          state_d   = START;
          // Pulse on START entry only if the master is already free.
          m_start_d = !m_busy;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        if (m_start_q) begin
          state_d = WAIT;
        end else if (!m_busy) begin
          m_start_d = 1'b1;
        end
      end
      WAIT: begin
        if (m_new_data) begin
          rsp_d   = m_data_out;
          cnt_d   = '0;
          state_d = (HOLD_CYC == 0) ? DONE : HOLD;
        end else if (cnt_q == TO_LAST) begin
          rsp_d      = '0;
          err_flag_d = 1'b1;
          cnt_d      = '0;
          state_d    = (HOLD_CYC == 0) ? DONE : HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        rr_ptr_d = (sel_q == SEL_W'(NREQ - 1)) ? '0 : sel_q + SEL_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    sel_onehot_d = NREQ'(1) << sel_d;
    ss_n_d       = '1;
    ack_d        = '0;
    err_d        = 1'b0;
    if (state_selects(state_d)) ss_n_d = ~sel_onehot_d;
    if (state_d == DONE) begin
      ack_d = sel_onehot_d;
      err_d = err_flag_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers; reset forces all selects high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      tx_q       <= '0;
      rsp_q      <= '0;
      err_flag_q <= 1'b0;
      ss_n_q     <= '1;
      m_start_q  <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      tx_q       <= tx_d;
      rsp_q      <= rsp_d;
      err_flag_q <= err_flag_d;
      ss_n_q     <= ss_n_d;
      m_start_q  <= m_start_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rsp_data  = rsp_q;
  assign ss_n      = ss_n_q;
  assign sel_id    = sel_q;
  assign m_start   = m_start_q;
  assign m_data_in = tx_q;

endmodule
